// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM states, opcode constants and flag bit positions for the cpu sequencer
package cpu_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_JE   = 4'b1001;
  localparam logic [3:0] OP_NOP  = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1011;
  localparam int CF = 2;
  localparam int SF = 1;
  localparam int ZF = 0;
endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction-memory fetch bus, req/addr from sequencer and ack/data from memory
interface cpu_sequencer_if #(parameter int IW = 16, parameter int PCW = 8);
  logic imem_req;
  logic [PCW-1:0] imem_addr;
  logic imem_ack;
  logic [IW-1:0] imem_data;
  modport master(output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/cpu_decode.sv
// cpu_decode: opcode and registered zf/sf to imm_sel, reg_en, alu_op, jump and halt selects
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       zf,
  input  logic       sf,
  output logic       imm_sel,
  output logic       reg_en,
  output logic       jmp_sel,
  output logic       halt_sel,
  output logic [1:0] alu_op
);
  always_comb begin
    imm_sel  = ~opcode[3] & opcode[2];
    reg_en   = ~(opcode[3] & ~opcode[2]);
    alu_op   = opcode[1:0];
    jmp_sel  = (opcode == OP_JMP) || (opcode == OP_JE && zf && !sf);
    halt_sel = opcode == OP_HALT;
  end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/exec/writeback controller owning pc, ir and {cf,sf,zf} flags
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int IW = 16,
  parameter int PCW = 8,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_sequencer_if.master       bus,
  input  logic                  cf_in,
  input  logic                  sf_in,
  input  logic                  zf_in,
  output logic [IW-1:0]         ir,
  output logic [PCW-1:0]        pc,
  output logic [2:0]            flags,
  output logic                  alu_en,
  output logic [1:0]            alu_op,
  output logic                  imm_sel,
  output logic                  rf_we,
  output logic                  halted
);
  state_t state, nxt;
  logic reg_en, jmp_sel, halt_sel;
  cpu_decode u_decode (
    .opcode(ir[IW-1:IW-4]),
    .zf(flags[ZF]),
    .sf(flags[SF]),
    .imm_sel(imm_sel),
    .reg_en(reg_en),
    .jmp_sel(jmp_sel),
    .halt_sel(halt_sel),
    .alu_op(alu_op)
  );
  assign bus.imem_addr = pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      flags <= '0;
    end else begin
      state <= nxt;
      if (state == FETCH && bus.imem_ack) ir <= bus.imem_data;
      if (state == EXEC && reg_en) flags <= {cf_in, sf_in, zf_in};
      if (state == WB) pc <= jmp_sel ? ir[PCW-1:0] : pc + PCW'(1);
    end
  end
  always_comb begin
    nxt = state;
    bus.imem_req = 1'b0;
    alu_en = 1'b0;
    rf_we = 1'b0;
    halted = 1'b0;
    case (state)
      FETCH: begin
        bus.imem_req = 1'b1;
        nxt = bus.imem_ack ? DECODE : FETCH;
      end
      DECODE: nxt = halt_sel ? HALT : EXEC;
      EXEC: begin
        alu_en = reg_en;
        nxt = WB;
      end
      WB: begin
        rf_we = reg_en;
        nxt = FETCH;
      end
      HALT: halted = 1'b1;
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench driving instructions against a per-instruction reference model
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cf_in = 1'b0, sf_in = 1'b0, zf_in = 1'b0;
  logic [15:0] ir;
  logic [7:0] pc;
  logic [2:0] flags;
  logic alu_en, imm_sel, rf_we, halted;
  logic [1:0] alu_op;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] mpc = 8'h00;
  logic [2:0] mflags = 3'b000;
  cpu_sequencer_if #(.IW(16), .PCW(8)) bus ();
  cpu_sequencer #(.IW(16), .PCW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .cf_in(cf_in), .sf_in(sf_in), .zf_in(zf_in),
    .ir(ir), .pc(pc), .flags(flags), .alu_en(alu_en), .alu_op(alu_op),
    .imm_sel(imm_sel), .rf_we(rf_we), .halted(halted)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic run_instr(input logic [15:0] instr, input int delay, input logic [2:0] fin);
    logic [3:0] op;
    logic ren, imm, tk;
    int c0;
    op = instr[15:12];
    ren = !(op inside {[4'h8:4'hB]});
    imm = op[3:2] == 2'b01;
    tk = op == 4'h8 || (op == 4'h9 && mflags[0] && !mflags[1]);
    c0 = cyc;
    for (int i = 0; i <= delay; i++) begin
      checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, mpc}) begin
        errors++;
        $display("FAIL fetch req/addr got %b/%h exp 1/%h", bus.imem_req, bus.imem_addr, mpc);
      end
      bus.imem_ack = (i == delay);
      bus.imem_data = (i == delay) ? instr : 16'hDEAD;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    {cf_in, sf_in, zf_in} = fin;
    checks++;
    if ({bus.imem_req, alu_en, rf_we, halted, ir} !== {4'b0000, instr}) begin
      errors++;
      $display("FAIL decode req/alu_en/rf_we/halted/ir got %b%b%b%b/%h exp 0000/%h",
               bus.imem_req, alu_en, rf_we, halted, ir, instr);
    end
    @(negedge clk);
    if (op == 4'hB) begin
      checks++;
      if ({halted, bus.imem_req, alu_en, rf_we} !== 4'b1000) begin
        errors++;
        $display("FAIL halt entry halted/req/alu_en/rf_we got %b%b%b%b exp 1000",
                 halted, bus.imem_req, alu_en, rf_we);
      end
      return;
    end
    checks++;
    if ({alu_en, rf_we, imm_sel, alu_op, bus.imem_req} !== {ren, 1'b0, imm, op[1:0], 1'b0}) begin
      errors++;
      $display("FAIL exec alu_en/rf_we/imm_sel/alu_op/req got %b%b%b%b%b exp %b%b%b%b%b",
               alu_en, rf_we, imm_sel, alu_op, bus.imem_req, ren, 1'b0, imm, op[1:0], 1'b0);
    end
    @(negedge clk);
    if (ren) mflags = fin;
    checks++;
    if ({rf_we, alu_en, flags} !== {ren, 1'b0, mflags}) begin
      errors++;
      $display("FAIL wb rf_we/alu_en/flags got %b%b%b exp %b%b%b", rf_we, alu_en, flags, ren, 1'b0, mflags);
    end
    mpc = tk ? instr[7:0] : mpc + 8'd1;
    @(negedge clk);
    checks++;
    if ({pc, bus.imem_req} !== {mpc, 1'b1} || cyc - c0 != delay + 4) begin
      errors++;
      $display("FAIL next pc/req/latency got %h/%b/%0d exp %h/1/%0d", pc, bus.imem_req, cyc - c0, mpc, delay + 4);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_data = 16'h0312;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.imem_req, bus.imem_addr, pc, ir, flags, alu_en, rf_we, halted} !== {1'b1, 8'h00, 8'h00, 16'h0000, 3'b000, 3'b000}) begin
      errors++;
      $display("FAIL reset req/addr/pc/ir/flags/strobes got %b/%h/%h/%h/%b/%b%b%b exp 1/00/00/0000/000/000",
               bus.imem_req, bus.imem_addr, pc, ir, flags, alu_en, rf_we, halted);
    end
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    mpc = 8'h00;
    mflags = 3'b000;
  endtask
  task automatic test_reg_op();
    run_instr(16'h0312, 0, 3'b000);
  endtask
  task automatic test_imm_delay();
    run_instr(16'h4005, 3, 3'($urandom));
  endtask
  task automatic test_je();
    run_instr(16'h0100, 0, 3'b001);
    run_instr(16'h9020, 0, 3'($urandom));
    run_instr(16'h0100, 1, 3'b011);
    run_instr(16'h9020, 0, 3'($urandom));
  endtask
  task automatic test_jmp_wrap();
    run_instr(16'h80FF, 0, 3'b000);
    run_instr(16'h8000, 2, 3'b111);
    run_instr(16'h80FF, 0, 3'b000);
    run_instr(16'hA000, 1, 3'b101);
  endtask
  task automatic test_random();
    logic [15:0] instr;
    for (int n = 0; n < 60; n++) begin
      instr = 16'($urandom);
      if (instr[15:12] == 4'hB) instr[15:12] = 4'h9;
      run_instr(instr, int'($urandom_range(0, 3)), 3'($urandom));
    end
  endtask
  task automatic test_halt();
    int bad;
    run_instr(16'hB000, 1, 3'b000);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.imem_ack = 1'($urandom);
      @(negedge clk);
      if ({halted, bus.imem_req, alu_en, rf_we} !== 4'b1000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt hold bad cycles got %0d exp 0", bad);
    end
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mpc = 8'h00;
    mflags = 3'b000;
    checks++;
    if ({halted, bus.imem_req, pc} !== {2'b01, 8'h00}) begin
      errors++;
      $display("FAIL halt exit halted/req/pc got %b/%b/%h exp 0/1/00", halted, bus.imem_req, pc);
    end
  endtask
  task automatic test_reset_mid();
    run_instr(16'h0001, 0, 3'b111);
    bus.imem_ack = 1'b1;
    bus.imem_data = 16'h1234;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    mpc = 8'h00;
    mflags = 3'b000;
    checks++;
    if ({ir, pc, flags, bus.imem_req} !== {16'h0000, 8'h00, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL reset in fetch ir/pc/flags/req got %h/%h/%b/%b exp 0000/00/000/1", ir, pc, flags, bus.imem_req);
    end
    run_instr(16'h0002, 0, 3'b101);
    bus.imem_ack = 1'b1;
    bus.imem_data = 16'h0333;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    {cf_in, sf_in, zf_in} = 3'b111;
    @(negedge clk);
    checks++;
    if (alu_en !== 1'b1) begin
      errors++;
      $display("FAIL exec before reset alu_en got %b exp 1", alu_en);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({rf_we, flags, bus.imem_req, pc} !== {1'b0, 3'b000, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL reset in exec rf_we/flags/req/pc got %b/%b/%b/%h exp 0/000/1/00", rf_we, flags, bus.imem_req, pc);
    end
    mpc = 8'h00;
    mflags = 3'b000;
    run_instr(16'hC0AA, 0, 3'b010);
  endtask
  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_data = 16'h0000;
    test_reset();
    test_reg_op();
    test_imm_delay();
    test_je();
    test_jmp_wrap();
    test_random();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
